// File: rtl/iq_fsk_gen_pkg.sv
// Shared types and helpers for the CPFSK I/Q stream generator.
//   gen_state_e : generator FSM states
//   amp_max     : full-scale positive amplitude for a given sample width
//   lut_entry   : one quarter-wave sine table entry, offset half a step so
//                 the table never holds an exact zero or an exact peak
package iq_fsk_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_LOAD    = 2'd2,
    ST_PRESENT = 2'd3
  } gen_state_e;

  localparam real PI_HALF = 1.5707963267948966;

  function automatic int amp_max(input int data_w);
    return (2 ** (data_w - 1)) - 1;
  endfunction

  // round(amp * sin(pi/2 * (k + 0.5) / 2^addr_w)); the argument is always
  // positive, so adding one half before truncation rounds to nearest.
  function automatic int lut_entry(input int k, input int data_w, input int addr_w);
    real amp;
    real ang;
    amp = real'(amp_max(data_w));
    ang = PI_HALF * (real'(k) + 0.5) / real'(2 ** addr_w);
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/iq_fsk_stream_gen_if.sv
// Stream bundle of the CPFSK generator.
//   s_bit_* : incoming symbol bit stream (1-bit AXI4-Stream, no tlast)
//   m_i_*   : I sample stream (sine)
//   m_q_*   : Q sample stream (cosine)
// Modport master is the generator side, slave is the producer/consumer side.
interface iq_fsk_stream_gen_if #(
  parameter int DATA_W = 16
);
  logic              s_bit_tdata;
  logic              s_bit_tvalid;
  logic              s_bit_tready;

  logic [DATA_W-1:0] m_i_tdata;
  logic              m_i_tvalid;
  logic              m_i_tready;
  logic              m_i_tlast;

  logic [DATA_W-1:0] m_q_tdata;
  logic              m_q_tvalid;
  logic              m_q_tready;
  logic              m_q_tlast;

  modport master (
    input  s_bit_tdata, s_bit_tvalid, m_i_tready, m_q_tready,
    output s_bit_tready,
    output m_i_tdata, m_i_tvalid, m_i_tlast,
    output m_q_tdata, m_q_tvalid, m_q_tlast
  );

  modport slave (
    output s_bit_tdata, s_bit_tvalid, m_i_tready, m_q_tready,
    input  s_bit_tready,
    input  m_i_tdata, m_i_tvalid, m_i_tlast,
    input  m_q_tdata, m_q_tvalid, m_q_tlast
  );
endinterface

// File: rtl/iq_quarter_sine_lut.sv
// Combinational quarter-wave sine ROM.
//   phase_top : top LUT_ADDR_W+2 bits of the phase (2 quadrant bits + index)
//   sample    : signed sine sample
// Odd quadrants read the table backwards, the upper half-cycle negates.
module iq_quarter_sine_lut
  import iq_fsk_gen_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int LUT_ADDR_W = 10
) (
  input  logic [LUT_ADDR_W+1:0]    phase_top,
  output logic signed [DATA_W-1:0] sample
);

  localparam int DEPTH = 2 ** LUT_ADDR_W;

  logic [DATA_W-1:0]     rom [DEPTH];
  logic [1:0]            quad;
  logic [LUT_ADDR_W-1:0] idx;
  logic [DATA_W-1:0]     mag;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom[k] = DATA_W'(lut_entry(k, DATA_W, LUT_ADDR_W));
  end

  assign quad   = phase_top[LUT_ADDR_W+1 -: 2];
  assign idx    = quad[0] ? ~phase_top[LUT_ADDR_W-1:0] : phase_top[LUT_ADDR_W-1:0];
  assign mag    = rom[idx];
  assign sample = quad[1] ? -$signed(mag) : $signed(mag);

endmodule

// File: rtl/iq_fsk_stream_gen.sv
// CPFSK I/Q stimulus source. Emits packets of NUM_SAMPLES sine/cosine
// samples on two independent AXI4-Stream masters; the tone of each
// SPS-sample symbol is chosen by one input bit. Phase is continuous.
//   clock, reset : clock, asynchronous active-high reset
//   start        : packet start pulse (ignored while busy)
//   freq0, freq1 : phase increments for bit 0 / bit 1, latched at start
//   busy, done   : packet in progress / one-cycle completion pulse
//   bus          : bit input stream plus I and Q output streams
// Build option IQ_FSK_GEN_PRBS_EN: bits come from an internal PRBS-7
// (x^7+x^6+1, seed 7'h7F) and the s_bit stream is not used.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_FETCH   | waiting for the next symbol bit
// ST_LOAD    | registering sin/cos of the current phase
// ST_PRESENT | sample offered on I and Q until both are accepted
module iq_fsk_stream_gen
  import iq_fsk_gen_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int PHASE_W     = 32,
  parameter int LUT_ADDR_W  = 10,
  parameter int SPS         = 8,
  parameter int NUM_SAMPLES = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [PHASE_W-1:0] freq0,
  input  logic [PHASE_W-1:0] freq1,
  output logic               busy,
  output logic               done,
  iq_fsk_stream_gen_if.master bus
);

  localparam int SAMP_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int SYM_W  = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [SAMP_W-1:0] LAST_SAMP = SAMP_W'(NUM_SAMPLES - 1);
  localparam logic [SYM_W-1:0]  LAST_SYM  = SYM_W'(SPS - 1);
  localparam int TOP_W = LUT_ADDR_W + 2;
  localparam logic [TOP_W-1:0] QUARTER = TOP_W'(1) << LUT_ADDR_W;

  gen_state_e state, state_nxt;

  logic [PHASE_W-1:0]       freq0_q, freq1_q, inc, phase;
  logic [SAMP_W-1:0]        samp_cnt;
  logic [SYM_W-1:0]         sym_cnt;
  logic signed [DATA_W-1:0] i_data, q_data, sin_i, sin_q;
  logic                     i_valid, q_valid, last_q, done_q;
  logic [TOP_W-1:0]         i_top, q_top;
  logic                     bit_ok, bit_val, bit_hs;
  logic                     i_acc, q_acc, retire;

`ifdef IQ_FSK_GEN_PRBS_EN
  logic [6:0] lfsr;
  logic       unused_bit_in;

  assign unused_bit_in    = bus.s_bit_tdata ^ bus.s_bit_tvalid;
  assign bit_ok           = 1'b1;
  assign bit_val          = lfsr[6];
  assign bus.s_bit_tready = 1'b0;
`else
  assign bit_ok           = bus.s_bit_tvalid;
  assign bit_val          = bus.s_bit_tdata;
  assign bus.s_bit_tready = (state == ST_FETCH);
`endif

  // cos(p) = sin(p + quarter turn); the offset lands entirely in the
  // quadrant bits, so only the LUT-facing slice needs the addition.
  assign i_top = phase[PHASE_W-1 -: TOP_W];
  assign q_top = i_top + QUARTER;

  iq_quarter_sine_lut #(.DATA_W(DATA_W), .LUT_ADDR_W(LUT_ADDR_W)) u_lut_i (
    .phase_top (i_top),
    .sample    (sin_i)
  );

  iq_quarter_sine_lut #(.DATA_W(DATA_W), .LUT_ADDR_W(LUT_ADDR_W)) u_lut_q (
    .phase_top (q_top),
    .sample    (sin_q)
  );

  // A channel counts as accepted if it already handshook earlier or does now.
  assign i_acc = !i_valid || bus.m_i_tready;
  assign q_acc = !q_valid || bus.m_q_tready;

  always_comb begin
    state_nxt = state;
    bit_hs    = 1'b0;
    retire    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (bit_ok) begin
          bit_hs    = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (i_acc && q_acc) begin
          retire = 1'b1;
          if (last_q)                  state_nxt = ST_IDLE;
          else if (sym_cnt == LAST_SYM) state_nxt = ST_FETCH;
          else                         state_nxt = ST_LOAD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      freq0_q  <= '0;
      freq1_q  <= '0;
      inc      <= '0;
      phase    <= '0;
      samp_cnt <= '0;
      sym_cnt  <= '0;
      i_data   <= '0;
      q_data   <= '0;
      i_valid  <= 1'b0;
      q_valid  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef IQ_FSK_GEN_PRBS_EN
      lfsr     <= 7'h7F;
`endif
    end else begin
      done_q <= retire && last_q;

      if (state == ST_IDLE && start) begin
        freq0_q  <= freq0;
        freq1_q  <= freq1;
        phase    <= '0;
        samp_cnt <= '0;
        sym_cnt  <= '0;
`ifdef IQ_FSK_GEN_PRBS_EN
        lfsr     <= 7'h7F;
`endif
      end

      if (bit_hs) begin
        inc <= bit_val ? freq1_q : freq0_q;
`ifdef IQ_FSK_GEN_PRBS_EN
        lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
`endif
      end

      if (state == ST_LOAD) begin
        i_data  <= sin_i;
        q_data  <= sin_q;
        last_q  <= (samp_cnt == LAST_SAMP);
        i_valid <= 1'b1;
        q_valid <= 1'b1;
      end

      if (state == ST_PRESENT) begin
        if (bus.m_i_tready) i_valid <= 1'b0;
        if (bus.m_q_tready) q_valid <= 1'b0;
        if (retire) begin
          phase    <= phase + inc;
          samp_cnt <= samp_cnt + 1'b1;
          sym_cnt  <= (sym_cnt == LAST_SYM) ? '0 : sym_cnt + 1'b1;
          last_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.m_i_tdata  = i_data;
  assign bus.m_i_tvalid = i_valid;
  assign bus.m_i_tlast  = last_q;
  assign bus.m_q_tdata  = q_data;
  assign bus.m_q_tvalid = q_valid;
  assign bus.m_q_tlast  = last_q;

  assign busy = (state != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_iq_fsk_stream_gen.sv
`timescale 1ns/1ps
module tb_iq_fsk_stream_gen;

  localparam int DATA_W      = 16;
  localparam int PHASE_W     = 32;
  localparam int LUT_ADDR_W  = 10;
  localparam int SPS         = 8;
  localparam int NUM_SAMPLES = 1000;
  localparam int NSYM        = (NUM_SAMPLES + SPS - 1) / SPS;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [PHASE_W-1:0] freq0, freq1;
  logic               busy, done;

  iq_fsk_stream_gen_if #(.DATA_W(DATA_W)) bus ();

  iq_fsk_stream_gen #(
    .DATA_W(DATA_W), .PHASE_W(PHASE_W), .LUT_ADDR_W(LUT_ADDR_W),
    .SPS(SPS), .NUM_SAMPLES(NUM_SAMPLES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .freq0 (freq0),
    .freq1 (freq1),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int data;
    bit last;
  } smp_t;

  smp_t        sb_i[$];
  smp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        pkt_bits [NSYM];
  logic [31:0] cfg_f0, cfg_f1;
  bit          skew = 1'b0;
  int          stall_at = -1;
  int          cyc = 0;
  int          retire_cyc = -100;
  int          done_cnt = 0;
  int          i_cnt = 0;
  int          q_cnt = 0;
  int          skew_cnt = 0;
  bit          il_seen = 1'b0;
  bit          ql_seen = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference sine straight from the table definition.
  function automatic int ref_sin(input logic [31:0] ph);
    logic [1:0] qd;
    int         idx;
    int         m;
    real        v;
    qd  = ph[31:30];
    idx = int'(ph[29:20]);
    if (qd[0]) idx = 1023 - idx;
    v = 32767.0 * $sin(3.141592653589793 / 2.0 * (real'(idx) + 0.5) / 1024.0);
    m = $rtoi(v + 0.5);
    return qd[1] ? -m : m;
  endfunction

  // Monitor / scoreboard
  always @(negedge clock) begin
    logic [31:0] ph;
    logic        b;
`ifdef IQ_FSK_GEN_PRBS_EN
    logic [6:0]  lf;
`endif
    smp_t        e;
    cyc++;
    if (reset) begin
      sb_i.delete();
      sb_q.delete();
      i_cnt   = 0;
      q_cnt   = 0;
      il_seen = 1'b0;
      ql_seen = 1'b0;
    end else begin
      if (start && !busy) begin
        ph = '0;
        b  = 1'b0;
`ifdef IQ_FSK_GEN_PRBS_EN
        lf = 7'h7F;
`endif
        for (int s = 0; s < NUM_SAMPLES; s++) begin
          if (s % SPS == 0) begin
`ifdef IQ_FSK_GEN_PRBS_EN
            b  = lf[6];
            lf = {lf[5:0], lf[6] ^ lf[5]};
`else
            b = pkt_bits[s / SPS];
`endif
          end
          sb_i.push_back('{ref_sin(ph), (s == NUM_SAMPLES - 1)});
          sb_q.push_back('{ref_sin(ph + 32'h4000_0000), (s == NUM_SAMPLES - 1)});
          ph = ph + (b ? cfg_f1 : cfg_f0);
        end
        i_cnt = 0;
        q_cnt = 0;
      end

      if (done) begin
        done_cnt++;
        chk("done_latency", cyc - retire_cyc, 1);
        chk("busy_at_done", busy, 0);
      end

      if (bus.m_q_tvalid && !bus.m_i_tvalid) skew_cnt++;

      if (bus.m_i_tvalid && bus.m_i_tready) begin
        if (sb_i.size() == 0) chk("sb_i_empty", 1, 0);
        else begin
          e = sb_i.pop_front();
          chk("i_data", $signed(bus.m_i_tdata), e.data);
          chk("i_last", bus.m_i_tlast, e.last);
          if (e.last) il_seen = 1'b1;
        end
        chk("align_i", (q_cnt == i_cnt || q_cnt == i_cnt + 1), 1);
        i_cnt++;
      end

      if (bus.m_q_tvalid && bus.m_q_tready) begin
        if (sb_q.size() == 0) chk("sb_q_empty", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("q_data", $signed(bus.m_q_tdata), e.data);
          chk("q_last", bus.m_q_tlast, e.last);
          if (e.last) ql_seen = 1'b1;
        end
        chk("align_q", (i_cnt == q_cnt || i_cnt == q_cnt + 1), 1);
        q_cnt++;
      end

      if (il_seen && ql_seen) begin
        retire_cyc = cyc;
        il_seen    = 1'b0;
        ql_seen    = 1'b0;
      end

`ifdef IQ_FSK_GEN_PRBS_EN
      chk("prbs_bit_ready", bus.s_bit_tready, 0);
`endif
    end
  end

  // Bit-stream driver, with an optional stall at one symbol boundary
  initial begin
    int bidx;
    bit hs, st, stalled;
    int c;
    bus.s_bit_tvalid = 1'b0;
    bus.s_bit_tdata  = 1'b0;
    bidx    = 0;
    stalled = 1'b0;
    forever begin
      @(negedge clock);
      hs = bus.s_bit_tvalid && bus.s_bit_tready;
      st = start && !busy && !reset;
      @(posedge clock);
      #1;
      if (st) begin
        bidx    = 0;
        stalled = 1'b0;
      end else if (hs) bidx++;
      if (reset) bus.s_bit_tvalid = 1'b0;
      else if (bidx == stall_at && !stalled && !st) begin
        bus.s_bit_tvalid = 1'b0;
        c = 0;
        while (!bus.s_bit_tready && c < 500) begin
          @(negedge clock);
          c++;
        end
        chk("stall_fetch_reached", bus.s_bit_tready, 1);
        repeat (20) begin
          @(negedge clock);
          chk("stall_i_valid", bus.m_i_tvalid, 0);
          chk("stall_q_valid", bus.m_q_tvalid, 0);
        end
        stalled = 1'b1;
        @(posedge clock);
        #1;
        bus.s_bit_tvalid = 1'b1;
        bus.s_bit_tdata  = pkt_bits[bidx];
      end else if (bidx < NSYM) begin
        bus.s_bit_tvalid = 1'b1;
        bus.s_bit_tdata  = pkt_bits[bidx];
      end else bus.s_bit_tvalid = 1'b0;
    end
  end

  // Ready driver: Q accepts one cycle in four while skew is on
  initial begin
    int rc;
    rc = 0;
    bus.m_i_tready = 1'b1;
    bus.m_q_tready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      rc++;
      bus.m_i_tready = 1'b1;
      bus.m_q_tready = skew ? (rc % 4 == 0) : 1'b1;
    end
  end

  task automatic run_packet(input logic [31:0] f0, input logic [31:0] f1, input int pattern,
                            input bit do_skew, input int stall, input bit check_lat,
                            input int abort_at);
    int d0;
    int c;
    cfg_f0 = f0;
    cfg_f1 = f1;
    for (int k = 0; k < NSYM; k++)
      pkt_bits[k] = (pattern == 0) ? 1'b0 :
                    (pattern == 1) ? 1'(k % 2) : 1'($urandom_range(0, 1));
    skew = do_skew;
`ifdef IQ_FSK_GEN_PRBS_EN
    stall_at = -1;
`else
    stall_at = stall;
`endif
    freq0 = f0;
    freq1 = f1;
    d0    = done_cnt;
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    freq0 = ~f0;
    freq1 = ~f1;
    chk("busy_after_start", busy, 1);
    if (check_lat) begin
      @(posedge clock);
      #1 chk("first_valid_not_early", bus.m_i_tvalid, 0);
      @(posedge clock);
      #1 chk("first_i_valid", bus.m_i_tvalid, 1);
      chk("first_q_valid", bus.m_q_tvalid, 1);
    end
    if (abort_at > 0) begin
      c = 0;
      while (i_cnt < abort_at && c < 10000) begin
        @(posedge clock);
        c++;
      end
      chk("abort_point_reached", (i_cnt >= abort_at), 1);
      #1 reset = 1'b1;
      #1;
      chk("abort_i_valid", bus.m_i_tvalid, 0);
      chk("abort_q_valid", bus.m_q_tvalid, 0);
      chk("abort_i_data", bus.m_i_tdata, 0);
      chk("abort_q_data", bus.m_q_tdata, 0);
      chk("abort_i_last", bus.m_i_tlast, 0);
      chk("abort_bit_ready", bus.s_bit_tready, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      chk("abort_no_done_pulse", done_cnt - d0, 0);
    end else begin
      c = 0;
      while (done_cnt == d0 && c < 20000) begin
        @(posedge clock);
        c++;
      end
      chk("packet_done", done_cnt - d0, 1);
      #1 chk("done_one_cycle", done, 0);
      chk("sb_i_drained", sb_i.size(), 0);
      chk("sb_q_drained", sb_q.size(), 0);
    end
    skew     = 1'b0;
    stall_at = -1;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    freq0  = '0;
    freq1  = '0;
    cfg_f0 = '0;
    cfg_f1 = '0;
    for (int k = 0; k < NSYM; k++) pkt_bits[k] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_i_valid", bus.m_i_tvalid, 0);
    chk("rst_q_valid", bus.m_q_tvalid, 0);
    chk("rst_i_data", bus.m_i_tdata, 0);
    chk("rst_q_data", bus.m_q_tdata, 0);
    chk("rst_i_last", bus.m_i_tlast, 0);
    chk("rst_q_last", bus.m_q_tlast, 0);
    chk("rst_bit_ready", bus.s_bit_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);

    // quarter-turn steps, all-zero bits, start latency
    run_packet(32'h4000_0000, 32'h1234_5678, 0, 1'b0, -1, 1'b1, 0);
    // phase continuity across alternating tones
    run_packet(32'h1000_0000, 32'h2000_0000, 1, 1'b0, -1, 1'b0, 0);
    // Q back-pressure skew plus a 20-cycle bit stall
    skew_cnt = 0;
    run_packet(32'h0123_4567, 32'h0456_789A, 2, 1'b1, 10, 1'b0, 0);
    chk("skew_observed", (skew_cnt > 0), 1);
    // abort by reset at sample 300, then a clean packet from phase 0
    run_packet(32'h0765_4321, 32'h0234_5678, 2, 1'b0, -1, 1'b0, 300);
    repeat (2) @(posedge clock);
    run_packet(32'h0A00_0000, 32'h0500_0000, 2, 1'b0, -1, 1'b1, 0);

    repeat (5) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
